// File: rtl/complex_fixed_point_multiplier_if.sv
// Operand/result bundle for the complex fixed-point multiplier.
// The master drives the operands and the slave returns the product.
interface complex_fixed_point_multiplier_if #(
   parameter int WIDTH = 16
);
   logic             enable;
   logic             conj;
   logic [WIDTH-1:0] a_re;
   logic [WIDTH-1:0] a_im;
   logic [WIDTH-1:0] b_re;
   logic [WIDTH-1:0] b_im;
   logic             done;
   logic [WIDTH-1:0] p_re;
   logic [WIDTH-1:0] p_im;
   logic             overflow;

   modport master (
      output enable, conj, a_re, a_im, b_re, b_im,
      input  done, p_re, p_im, overflow
   );

   modport slave (
      input  enable, conj, a_re, a_im, b_re, b_im,
      output done, p_re, p_im, overflow
   );
endinterface

// File: rtl/complex_fixed_point_multiplier.sv
// Pipelined signed fixed-point complex multiplier, P = A*B or A*conj(B).
// Stages: operand reg, partial products, sums, round/saturate reg, optional extra regs.

module cfpm_rndsat #(
   parameter int WIDTH = 16,
   parameter int S     = 15,
   parameter int ROUND = 0
) (
   input  logic [2*WIDTH:0]  x,
   output logic [WIDTH-1:0]  y,
   output logic              ovf
);
   localparam int RW = 2*WIDTH + 2;
   localparam logic signed [RW-1:0] RND  =
      (ROUND != 0 && S > 0) ? (RW'(1) << (S > 0 ? S-1 : 0)) : '0;
   localparam logic signed [RW-1:0] MAXV = RW'((2**(WIDTH-1)) - 1);
   localparam logic signed [RW-1:0] MINV = ~MAXV;

   logic signed [RW-1:0] t;
   logic signed [RW-1:0] sh;

   // One guard bit above the sum keeps the rounding add from wrapping.
   always_comb begin
      t   = $signed({x[2*WIDTH], x}) + RND;
      sh  = t >>> S;
      y   = sh[WIDTH-1:0];
      ovf = 1'b0;
      if (sh > MAXV) begin
         y   = MAXV[WIDTH-1:0];
         ovf = 1'b1;
      end else if (sh < MINV) begin
         y   = MINV[WIDTH-1:0];
         ovf = 1'b1;
      end
   end
endmodule

module complex_fixed_point_multiplier #(
   parameter int WIDTH             = 16,
   parameter int EXP_WIDTH_A       = 15,
   parameter int EXP_WIDTH_B       = 15,
   parameter int EXP_WIDTH_PRODUCT = 15,
   parameter int ROUND             = 0,
   parameter int EXTRA_STAGES      = 0
) (
   input  logic                            clk,
   input  logic                            reset,
   complex_fixed_point_multiplier_if.slave bus
);
   localparam int S      = EXP_WIDTH_A + EXP_WIDTH_B - EXP_WIDTH_PRODUCT;
   localparam int STAGES = 4 + EXTRA_STAGES;
   localparam int PW     = 2*WIDTH;

   logic [STAGES:0]                        vld_pipe;
   logic [1:0][WIDTH-1:0]                  a_q, b_q;
   logic                                   conj_q, conj_q2;
   logic signed [PW-1:0]                   rr, ii, ri, ir;
   logic signed [PW:0]                     rr_x, ii_x, ri_x, ir_x;
   logic [1:0][PW:0]                       sum_q;
   logic [1:0][WIDTH-1:0]                  res_d;
   logic [1:0]                             ovf_d;
   logic [EXTRA_STAGES:0][1:0][WIDTH-1:0]  res_q;
   logic [EXTRA_STAGES:0]                  ovf_q;

   assign vld_pipe[0] = bus.enable;

   always_ff @(posedge clk) begin
      if (reset) vld_pipe[STAGES:1] <= '0;
      else       vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
   end

   // Index 0 = real, 1 = imaginary throughout.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         conj_q <= 1'b0;
      end else if (bus.enable) begin
         a_q    <= {bus.a_im, bus.a_re};
         b_q    <= {bus.b_im, bus.b_re};
         conj_q <= bus.conj;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr      <= '0;
         ii      <= '0;
         ri      <= '0;
         ir      <= '0;
         conj_q2 <= 1'b0;
      end else if (vld_pipe[1]) begin
         rr      <= $signed(a_q[0]) * $signed(b_q[0]);
         ii      <= $signed(a_q[1]) * $signed(b_q[1]);
         ri      <= $signed(a_q[0]) * $signed(b_q[1]);
         ir      <= $signed(a_q[1]) * $signed(b_q[0]);
         conj_q2 <= conj_q;
      end
   end

   assign rr_x = {rr[PW-1], rr};
   assign ii_x = {ii[PW-1], ii};
   assign ri_x = {ri[PW-1], ri};
   assign ir_x = {ir[PW-1], ir};

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q <= '0;
      end else if (vld_pipe[2]) begin
         sum_q[0] <= conj_q2 ? rr_x + ii_x : rr_x - ii_x;
         sum_q[1] <= conj_q2 ? ir_x - ri_x : ri_x + ir_x;
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_comp
      cfpm_rndsat #(.WIDTH(WIDTH), .S(S), .ROUND(ROUND)) u_rs (
         .x   (sum_q[i]),
         .y   (res_d[i]),
         .ovf (ovf_d[i])
      );
   end

   // Every result stage holds through bubbles so outputs keep the last result.
   always_ff @(posedge clk) begin
      if (reset) begin
         res_q <= '0;
         ovf_q <= '0;
      end else begin
         if (vld_pipe[3]) begin
            res_q[0] <= res_d;
            ovf_q[0] <= |ovf_d;
         end
         for (int k = 1; k <= EXTRA_STAGES; k++) begin
            if (vld_pipe[3+k]) begin
               res_q[k] <= res_q[k-1];
               ovf_q[k] <= ovf_q[k-1];
            end
         end
      end
   end

   assign bus.done     = vld_pipe[STAGES];
   assign bus.p_re     = res_q[EXTRA_STAGES][0];
   assign bus.p_im     = res_q[EXTRA_STAGES][1];
   assign bus.overflow = ovf_q[EXTRA_STAGES];
endmodule
